seg_scan_ctrl: RTL and testbench

Parametrised multiplexed seven-segment display controller for N common-anode digits on the Basys-3 style board.
- Time-multiplexes N BCD/hex nibbles onto a shared active-low segment bus and active-low anode lines.
- Adds per-digit decimal points, leading-zero blanking, PWM brightness and tear-free double-buffered updates.
- Sits between counter/timer datapaths and the board's seg/dp/an pins.

---
 rtl/seg_pkg.sv | 25 ++
 rtl/seg_scan_ctrl_if.sv | 22 ++
 rtl/seg_decode.sv | 37 +++
 rtl/seg_scan_ctrl.sv | 112 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Segment pattern constants shared by the seven-segment scan controller.
// Patterns are active-low and written a..g from left to right.
package seg_pkg;

  typedef logic [0:6] seg_t;

  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b1100000;
  localparam seg_t SEG_C     = 7'b0110001;
  localparam seg_t SEG_D     = 7'b1000010;
  localparam seg_t SEG_E     = 7'b0110000;
  localparam seg_t SEG_F     = 7'b0111000;
  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Control/data bundle driven by the datapath into the display controller.
interface seg_scan_ctrl_if #(
  parameter int N_DIGITS = 4,
  parameter int BRIGHT_W = 3
);

  logic [4*N_DIGITS-1:0] digits_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic                  load;
  logic                  lz_blank;
  logic                  blank_all;
  logic [BRIGHT_W-1:0]   brightness;

  modport master (
    output digits_in, dp_in, load, lz_blank, blank_all, brightness
  );

  modport slave (
    input digits_in, dp_in, load, lz_blank, blank_all, brightness
  );

endinterface

// File: rtl/seg_decode.sv
// Nibble to active-low segment decoder.
// Define SEG_HEX_EN to show A-F for 10-15; otherwise those values are blank.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
`ifdef SEG_HEX_EN
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
`else
      4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF: seg = SEG_BLANK;
`endif
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed N-digit seven-segment controller: double-buffered digits, leading-zero
// blanking, PWM brightness, registered outputs. Hex glyphs enabled by SEG_HEX_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int DWELL_TICKS = 100_000,
  parameter int BRIGHT_W    = 3
) (
  input  logic                clk_100MHz,
  input  logic                reset,
  seg_scan_ctrl_if.slave      ctrl,
  output seg_t                seg,
  output logic                dp,
  output logic [N_DIGITS-1:0] digit,
  output logic                frame_done
);

  localparam int TIMER_W  = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam int THRESH_W = $clog2(DWELL_TICKS + 1);
  localparam int SEL_W    = $clog2(N_DIGITS);

  localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(DWELL_TICKS - 1);
  localparam logic [SEL_W-1:0]    SEL_LAST    = SEL_W'(N_DIGITS - 1);
  localparam logic [THRESH_W-1:0] THRESH_FULL = THRESH_W'(DWELL_TICKS);

  logic [TIMER_W-1:0]    timer;
  logic [SEL_W-1:0]      sel;
  logic [THRESH_W-1:0]   thresh;
  logic [4*N_DIGITS-1:0] shadow_digits, active_digits;
  logic [N_DIGITS-1:0]   shadow_dp, active_dp;
  logic [N_DIGITS-1:0]   lz_hide;
  logic                  upper_zero;
  logic                  boundary;
  logic                  lit;
  logic [3:0]            cur_nib;
  seg_t                  dec_seg;

  assign boundary = (sel == SEL_LAST) && (timer == TIMER_LAST);

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      timer <= '0;
      sel   <= '0;
    end else if (timer == TIMER_LAST) begin
      timer <= '0;
      sel   <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // A load landing on the boundary bypasses the shadow so it still makes this frame swap.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      shadow_digits <= '0;
      shadow_dp     <= '0;
      active_digits <= '0;
      active_dp     <= '0;
      thresh        <= THRESH_FULL;
    end else begin
      if (ctrl.load) begin
        shadow_digits <= ctrl.digits_in;
        shadow_dp     <= ctrl.dp_in;
      end
      if (boundary) begin
        active_digits <= ctrl.load ? ctrl.digits_in : shadow_digits;
        active_dp     <= ctrl.load ? ctrl.dp_in     : shadow_dp;
        thresh        <= THRESH_W'(((64'(ctrl.brightness) + 64'd1) * 64'(DWELL_TICKS)) >> BRIGHT_W);
      end
    end
  end

  // Walk from the top digit down; a digit hides while everything above it is zero.
  always_comb begin
    upper_zero = 1'b1;
    lz_hide    = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (active_digits[4*i +: 4] == 4'h0);
      lz_hide[i] = ctrl.lz_blank && upper_zero && (i != 0);
    end
  end

  assign cur_nib = active_digits[{sel, 2'b00} +: 4];
  assign lit     = (THRESH_W'(timer) < thresh) && !ctrl.blank_all;

  seg_decode u_decode (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      digit      <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (lit) begin
        digit <= ~(N_DIGITS'(1) << sel);
        seg   <= lz_hide[sel] ? SEG_BLANK : dec_seg;
        dp    <= ~active_dp[sel];
      end else begin
        digit <= '1;
        seg   <= SEG_BLANK;
        dp    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with N_DIGITS=4, DWELL_TICKS=8, BRIGHT_W=3.
// Hex expectation follows SEG_HEX_EN.
module tb_seg_scan_ctrl;

  localparam logic [6:0] E0    = 7'b0000001;
  localparam logic [6:0] E1    = 7'b1001111;
  localparam logic [6:0] E2    = 7'b0010010;
  localparam logic [6:0] E3    = 7'b0000110;
  localparam logic [6:0] E4    = 7'b1001100;
  localparam logic [6:0] E5    = 7'b0100100;
  localparam logic [6:0] EOFF  = 7'b1111111;
`ifdef SEG_HEX_EN
  localparam logic [6:0] EHEXB = 7'b1100000;
`else
  localparam logic [6:0] EHEXB = 7'b1111111;
`endif

  logic       clk_100MHz;
  logic       reset;
  logic [0:6] seg;
  logic       dp;
  logic [3:0] digit;
  logic       frame_done;

  int n_cmp;
  int n_err;
  int edges;
  int lit_cnt;

  seg_scan_ctrl_if #(.N_DIGITS(4), .BRIGHT_W(3)) ctrl_bus ();

  seg_scan_ctrl #(
    .N_DIGITS    (4),
    .DWELL_TICKS (8),
    .BRIGHT_W    (3)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .ctrl       (ctrl_bus.slave),
    .seg        (seg),
    .dp         (dp),
    .digit      (digit),
    .frame_done (frame_done)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  task automatic wait_edge(input int k);
    while (edges < k) begin
      @(posedge clk_100MHz);
      #1;
      edges++;
    end
  endtask

  task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h (edge %0d)", tag, observed, expected, edges);
    end
  endtask

  task automatic check_display(input string tag, input logic [3:0] exp_digit, input logic [6:0] exp_seg,
                               input logic exp_dp);
    check_output({tag, ".digit"}, 16'(digit), 16'(exp_digit));
    check_output({tag, ".seg"}, 16'(seg), 16'(exp_seg));
    check_output({tag, ".dp"}, 16'(dp), 16'(exp_dp));
  endtask

  task automatic apply_stimulus(input logic [15:0] d, input logic [3:0] p);
    ctrl_bus.digits_in = d;
    ctrl_bus.dp_in     = p;
    ctrl_bus.load      = 1'b1;
    wait_edge(edges + 1);
    ctrl_bus.load      = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    edges = 0;
    reset = 1'b1;
    ctrl_bus.digits_in  = '0;
    ctrl_bus.dp_in      = '0;
    ctrl_bus.load       = 1'b0;
    ctrl_bus.lz_blank   = 1'b0;
    ctrl_bus.blank_all  = 1'b0;
    ctrl_bus.brightness = 3'd7;

    repeat (3) @(negedge clk_100MHz);
    check_display("reset", 4'hF, EOFF, 1'b1);
    check_output("reset.frame_done", 16'(frame_done), 16'd0);

    // Load lands in the first cycle; frame 1 still shows the reset zeros.
    @(negedge clk_100MHz);
    reset = 1'b0;
    edges = 0;
    apply_stimulus(16'h1234, 4'b0000);
    check_display("f1.d0", 4'b1110, E0, 1'b1);
    wait_edge(9);
    check_display("f1.d1", 4'b1101, E0, 1'b1);
    wait_edge(31);
    check_output("f1.fd_early", 16'(frame_done), 16'd0);
    wait_edge(32);
    check_output("f1.fd", 16'(frame_done), 16'd1);
    check_output("f1.d3", 16'(digit), 16'b0111);
    wait_edge(33);
    check_output("f2.fd_low", 16'(frame_done), 16'd0);
    check_display("f2.d0", 4'b1110, E4, 1'b1);
    wait_edge(41);
    check_display("f2.d1", 4'b1101, E3, 1'b1);
    wait_edge(49);
    check_display("f2.d2", 4'b1011, E2, 1'b1);
    wait_edge(57);
    check_display("f2.d3", 4'b0111, E1, 1'b1);
    wait_edge(64);
    check_output("f2.fd", 16'(frame_done), 16'd1);

    ctrl_bus.lz_blank = 1'b1;
    apply_stimulus(16'h0050, 4'b1000);
    wait_edge(97);
    check_display("lz.d0", 4'b1110, E0, 1'b1);
    wait_edge(105);
    check_display("lz.d1", 4'b1101, E5, 1'b1);
    wait_edge(113);
    check_display("lz.d2", 4'b1011, EOFF, 1'b1);
    wait_edge(121);
    check_display("lz.d3", 4'b0111, EOFF, 1'b0);

    // Loads during a frame must not show up until the next boundary.
    ctrl_bus.lz_blank = 1'b0;
    apply_stimulus(16'h1111, 4'b0000);
    for (int d = 0; d < 4; d++) begin
      if (d == 2) begin
        wait_edge(140);
        apply_stimulus(16'h2222, 4'b0000);
      end
      wait_edge(129 + 8*d);
      check_output($sformatf("tear1.d%0d", d), 16'(seg), 16'(E1));
    end
    for (int d = 0; d < 4; d++) begin
      if (d == 1) begin
        wait_edge(165);
        apply_stimulus(16'h1111, 4'b0000);
      end
      wait_edge(161 + 8*d);
      check_output($sformatf("tear2.d%0d", d), 16'(seg), 16'(E2));
    end

    wait_edge(191);
    apply_stimulus(16'h3333, 4'b0000);
    wait_edge(193);
    check_display("bypass.d0", 4'b1110, E3, 1'b1);
    wait_edge(201);
    check_display("bypass.d1", 4'b1101, E3, 1'b1);

    ctrl_bus.brightness = 3'd1;
    wait_edge(224);
    lit_cnt = 0;
    for (int k = 225; k <= 232; k++) begin
      wait_edge(k);
      if (digit != 4'hF) lit_cnt++;
      check_output("dim.one_anode", 16'($countones(~digit) <= 1), 16'd1);
    end
    check_output("dim.lit_cycles", 16'(lit_cnt), 16'd2);

    ctrl_bus.brightness = 3'd7;
    wait_edge(256);
    lit_cnt = 0;
    for (int k = 257; k <= 264; k++) begin
      wait_edge(k);
      if (digit != 4'hF) lit_cnt++;
    end
    check_output("full.lit_cycles", 16'(lit_cnt), 16'd8);

    ctrl_bus.blank_all = 1'b1;
    wait_edge(265);
    check_display("blank_all", 4'hF, EOFF, 1'b1);
    ctrl_bus.blank_all = 1'b0;
    wait_edge(266);
    check_display("blank_release", 4'b1101, E3, 1'b1);

    apply_stimulus(16'h000B, 4'b0001);
    wait_edge(289);
    check_display("hex.d0", 4'b1110, EHEXB, 1'b0);

    // Asynchronous reset in the middle of a dwell clears outputs without a clock edge.
    wait_edge(292);
    #2;
    reset = 1'b1;
    #1;
    check_display("midreset", 4'hF, EOFF, 1'b1);
    check_output("midreset.frame_done", 16'(frame_done), 16'd0);
    @(negedge clk_100MHz);
    reset = 1'b0;
    edges = 0;
    wait_edge(1);
    check_display("restart.d0", 4'b1110, E0, 1'b1);
    wait_edge(9);
    check_output("restart.d1", 16'(digit), 16'b1101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
